// File: rtl/timebase_gen.sv
// timebase_gen: decade-style tick strobe chain plus a one-shot/periodic countdown timer on the base tick.
module timebase_gen #(
  parameter int CLK_PER_TICK = 50000,
  parameter int STAGE_DIV    = 10,
  parameter int N_STAGES     = 4,
  parameter int DUR_W        = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                enable,
  input  logic                start,
  input  logic [DUR_W-1:0]    duration,
  input  logic                repeat_en,
  output logic [N_STAGES-1:0] tick,
  output logic                busy,
  output logic                done,
  output logic [DUR_W-1:0]    remaining
);
  localparam int CW = $clog2(CLK_PER_TICK);
  localparam int SW = $clog2(STAGE_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(CLK_PER_TICK - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STAGE_DIV - 1);
  localparam logic [DUR_W-1:0] ONE = DUR_W'(1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [CW-1:0]       base_cnt;
  logic [N_STAGES-1:0] tick_nxt;
  logic [0:0]          state;
  logic                mode;
  logic [DUR_W-1:0]    dur_l;
  // tick_nxt[0] carries enable, so every stage strobe is squashed while disabled
  assign tick_nxt[0] = enable && base_cnt == C_LAST;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      base_cnt <= '0;
      tick     <= '0;
    end else begin
      base_cnt <= (!enable || base_cnt == C_LAST) ? '0 : base_cnt + 1'b1;
      tick     <= tick_nxt;
    end
  for (genvar k = 1; k < N_STAGES; k++) begin : g_stage
    logic [SW-1:0] cnt;
    assign tick_nxt[k] = tick_nxt[k-1] && cnt == S_LAST;
    always_ff @(posedge Clk or negedge Rst)
      if (!Rst) cnt <= '0;
      else if (!enable) cnt <= '0;
      else if (tick_nxt[k-1]) cnt <= cnt == S_LAST ? '0 : cnt + 1'b1;
  end
  // start outranks a coincident tick; a zero-length start expires immediately
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state     <= IDLE;
      mode      <= 1'b0;
      dur_l     <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else if (start) begin
      done      <= duration == '0;
      state     <= duration == '0 ? IDLE : RUN;
      remaining <= duration;
      if (duration != '0) begin
        dur_l <= duration;
        mode  <= repeat_en;
      end
    end else if (state == RUN && tick[0]) begin
      done      <= remaining == ONE;
      remaining <= remaining != ONE ? remaining - 1'b1 : mode ? dur_l : '0;
      state     <= (remaining == ONE && !mode) ? IDLE : RUN;
    end else begin
      done <= 1'b0;
    end
  assign busy = state == RUN;
endmodule

// File: tb/tb_timebase_gen.sv
// tb_timebase_gen: directed checks of tick phasing, enable gating, timer modes, priority and async reset.
module tb_timebase_gen;
  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [7:0] duration = '0;
  logic       rpt = 1'b0;
  logic [2:0] tick;
  logic       busy;
  logic       done;
  logic [7:0] remaining;
  int total = 0;
  int bad = 0;
  int e = 0;

  timebase_gen #(.CLK_PER_TICK(5), .STAGE_DIV(3), .N_STAGES(3), .DUR_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .enable(enable), .start(start), .duration(duration),
    .repeat_en(rpt), .tick(tick), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         e;
    logic       st;
    logic [7:0] dur;
    logic       rp;
    logic       b;
    logic       d;
    logic [7:0] rem;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(int e_, logic st_, logic [7:0] dur_, logic rp_, logic b_, logic d_, logic [7:0] rem_);
    vec_t v;
    v.e = e_; v.st = st_; v.dur = dur_; v.rp = rp_; v.b = b_; v.d = d_; v.rem = rem_;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, e, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    e++;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_tick"}, 32'(tick), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_rem"}, 32'(remaining), 0);
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    enable = 1'b0;
    start = 1'b0;
    #1;
    chk_zero("rst");
    @(negedge Clk);
    @(negedge Clk);
    chk_zero("rst_hold");
    Rst = 1'b1;
    enable = 1'b1;
    e = 0;
  endtask

  function automatic logic [2:0] exp_tick(int n);
    return {n % 45 == 0, n % 15 == 0, n % 5 == 0};
  endfunction

  initial begin
    // free-running tick chain
    do_reset();
    for (int i = 1; i <= 50; i++) begin
      step();
      chk("tick_free", 32'(tick), 32'(exp_tick(e)));
    end
    chk("idle_busy", 32'(busy), 0);

    // enable low for edges 12..19 clears divider phase and stage counters
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      enable = !(i >= 12 && i < 20);
      step();
      chk("tick_en", 32'(tick), i < 12 ? 32'(exp_tick(i)) : i < 20 ? 0 : 32'(exp_tick(i - 19)));
    end

    // timer table: one-shot, periodic, zero-duration, restart priority
    do_reset();
    tv.push_back(mk( 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk( 2, 1, 3, 0, 1, 0, 3));
    tv.push_back(mk( 5, 0, 3, 0, 1, 0, 3));
    tv.push_back(mk( 6, 0, 3, 0, 1, 0, 2));
    tv.push_back(mk(10, 0, 3, 0, 1, 0, 2));
    tv.push_back(mk(11, 0, 3, 0, 1, 0, 1));
    tv.push_back(mk(15, 0, 3, 0, 1, 0, 1));
    tv.push_back(mk(16, 0, 3, 0, 0, 1, 0));
    tv.push_back(mk(17, 0, 3, 0, 0, 0, 0));
    tv.push_back(mk(18, 1, 2, 1, 1, 0, 2));
    tv.push_back(mk(21, 0, 2, 1, 1, 0, 1));
    tv.push_back(mk(26, 0, 2, 1, 1, 1, 2));
    tv.push_back(mk(27, 0, 2, 1, 1, 0, 2));
    tv.push_back(mk(31, 0, 7, 0, 1, 0, 1));
    tv.push_back(mk(36, 0, 7, 0, 1, 1, 2));
    tv.push_back(mk(41, 0, 7, 0, 1, 0, 1));
    tv.push_back(mk(46, 0, 7, 0, 1, 1, 2));
    tv.push_back(mk(47, 0, 7, 0, 1, 0, 2));
    tv.push_back(mk(48, 1, 0, 1, 0, 1, 0));
    tv.push_back(mk(49, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(51, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(52, 1, 4, 0, 1, 0, 4));
    tv.push_back(mk(56, 0, 4, 0, 1, 0, 3));
    tv.push_back(mk(61, 0, 4, 0, 1, 0, 2));
    tv.push_back(mk(66, 0, 4, 0, 1, 0, 1));
    tv.push_back(mk(71, 1, 1, 0, 1, 0, 1));
    tv.push_back(mk(75, 0, 1, 0, 1, 0, 1));
    tv.push_back(mk(76, 0, 1, 0, 0, 1, 0));
    tv.push_back(mk(77, 0, 1, 0, 0, 0, 0));
    foreach (tv[i]) begin
      while (e < tv[i].e - 1) begin
        start = 1'b0;
        duration = tv[i].dur;
        rpt = tv[i].rp;
        step();
      end
      start = tv[i].st;
      duration = tv[i].dur;
      rpt = tv[i].rp;
      step();
      start = 1'b0;
      chk("tv_busy", 32'(busy), 32'(tv[i].b));
      chk("tv_done", 32'(done), 32'(tv[i].d));
      chk("tv_rem", 32'(remaining), 32'(tv[i].rem));
      chk("tv_tick0", 32'(tick[0]), 32'(e % 5 == 0));
    end

    // async reset while running and while tick[0] is high
    start = 1'b1;
    duration = 8'd5;
    rpt = 1'b1;
    step();
    start = 1'b0;
    chk("ar_busy", 32'(busy), 1);
    chk("ar_rem", 32'(remaining), 5);
    while (e < 80) step();
    chk("ar_tick0", 32'(tick[0]), 1);
    #2;
    Rst = 1'b0;
    #2;
    chk_zero("ar_async");
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("ar_post_done", 32'(done), 0);
      chk("ar_post_busy", 32'(busy), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timebase_gen.md
# timebase_gen

Parametrised timebase and interval timer for the memory game. It divides `Clk` into a chain of decade-style tick strobes, for example 1 ms, 10 ms, 100 ms and 1 s at 50 MHz. It also provides a loadable one-shot/periodic countdown timer clocked by the base tick. Game FSMs use it for LED display timing, player-response timeouts and blink rates, replacing per-use single-period pulse counters.

## Interface
Parameters:
- `CLK_PER_TICK`, default 50000: `Clk` cycles per base tick (`tick[0]`); legal range ≥2.
- `STAGE_DIV`, default 10: ratio between successive tick stages; legal range ≥2.
- `N_STAGES`, default 4: number of tick outputs; legal range ≥1.
- `DUR_W`, default 16: width of the timer duration and remaining count.

Ports:
- `Clk` in 1: system clock; single clock domain.
- `Rst` in 1: asynchronous, active-low reset.
- `enable` in 1: runs the tick divider; low clears the divider.
- `start` in 1: single-cycle timer load/restart request.
- `duration` in DUR_W: timer length in base ticks, sampled when `start` is high.
- `repeat` in 1: timer mode, sampled when `start` is high; 1 = periodic, 0 = one-shot.
- `tick` out N_STAGES: one-cycle strobes; `tick[k]` period is CLK_PER_TICK·STAGE_DIV^k cycles.
- `busy` out 1: timer is running.
- `done` out 1: one-cycle strobe on timer expiry.
- `remaining` out DUR_W: current timer count in base ticks.

## Operation
- Reset (`Rst`=0, asynchronous): all counters are cleared. Output values during reset: `tick`=0, `busy`=0, `done`=0, `remaining`=0, latched mode=0.
- Base divider: the counter is width $clog2(CLK_PER_TICK). It counts enabled cycles. `tick[0]` is high for exactly one cycle per CLK_PER_TICK enabled cycles.
- Stage k≥1: a counter 0..STAGE_DIV-1 advances on each `tick[k-1]`. `tick[k]` is asserted in the same cycle as the STAGE_DIV-th `tick[k-1]`. All asserted stages are coincident; there is no skew.
- `enable`=0: the base and stage counters clear to 0 and all `tick` bits are 0 from the next cycle. Phase restarts from zero when `enable` returns high.
- Timer states: IDLE (`busy`=0) and RUN (`busy`=1). `start` is accepted in any state, regardless of `enable`.
- `start` with `duration`≠0: load `remaining`=`duration`, latch `repeat`, enter RUN. No `done` is asserted, even if a run was in progress (restart aborts it silently).
- `start` with `duration`=0: `done`=1 for one cycle, go to IDLE, `remaining`=0. This applies regardless of `repeat`.
- In RUN, each sampled `tick[0]`=1 with `remaining`>1 decrements `remaining`.
- In RUN, a sampled `tick[0]`=1 with `remaining`=1 is expiry, which asserts `done`=1 for one cycle:
  - One-shot: go to IDLE with `remaining`=0.
  - Periodic: reload the latched duration and stay in RUN.
- The duration for periodic reload is latched at `start`. Later changes to the `duration` input are ignored.
- `start` has priority over a simultaneous decrement or expiry. The `tick[0]` coincident with `start` is not counted, and no `done` is asserted in that case.
- While `enable`=0, the timer holds its state (no ticks arrive). It resumes counting when ticks resume.
- Asynchronous reset mid-run: everything is immediately forced to reset values. No `done` is asserted.

## Timing
- All outputs are registered. Nothing is combinational from inputs.
- Edge numbering: edge 1 is the first rising edge with `Rst`=1 and `enable`=1.
- `tick[0]` is high in the cycle following edges n·CLK_PER_TICK.
- `tick[k]` is high in the cycle following edges n·CLK_PER_TICK·STAGE_DIV^k.
- The timer samples the registered `tick[0]`. Consequently, `remaining`/`done`/`busy` update at the edge after a `tick[0]` cycle, which is a 1-cycle lag.
- `start` sampled at edge E: `busy` and `remaining` are valid after E (latency 1). For `duration`=0, `done` is high in the cycle after E.
- One-shot run of D ticks: `done` occurs on the edge following the D-th `tick[0]` after start. `busy` falls at the same edge `done` rises.

## Test plan
Bench parameters: CLK_PER_TICK=5, STAGE_DIV=3, N_STAGES=3, DUR_W=8.
- Reset release then `enable`=1: `tick[0]` after edges 5,10,15,…; `tick[1]` after edges 15,30; `tick[2]` after edge 45, coincident with `tick[0]` and `tick[1]`. All outputs are 0 during reset.
- `enable` dropped at edge 12 and raised at edge 20: no ticks in between. Next `tick[0]` arrives 5 enabled edges later (edge 24); the stage counters are also cleared.
- `start` at edge 2 with `duration`=3 and `repeat`=0: `busy`=1 and `remaining`=3 after edge 2. `remaining` is 2 after edge 6 and 1 after edge 11. `done`=1 and `busy`=0 after edge 16, with `remaining`=0.
- `repeat`=1 with `duration`=2: `done` pulses every 10 cycles. `busy` stays 1 and `remaining` reloads to 2 at each `done`. A subsequent `start` with `duration`=0 gives a single `done` and IDLE.
- Restart and priority: `start` with `duration`=4, then `start` with `duration`=1 on the cycle expiry would occur: no `done` is asserted and `remaining`=1. `done` occurs one tick later.
- Async `Rst` low mid-run (between clock edges): `busy`, `remaining` and `tick` go to 0 immediately. No `done` is asserted after release.
